// File: rtl/rsdiv_pkg.sv
// Shared definitions for the repeated-subtraction divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default operand width and the 3-bit control FSM state encoding.
package rsdiv_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        SUB   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rsdiv_if.sv
// Request/result bundle between a requester and the divider.
// Latency: n/a (wiring only).
// Backpressure: start is level-held by the master until done is seen.
// Signals: start, dividend, divisor (master->slave); quotient, remainder,
// busy, done and, when RSDIV_ERR_EN is defined, err (slave->master).
interface rsdiv_if
    import rsdiv_pkg::*;
#(
    parameter int W = W_DEF
);

    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
`ifdef RSDIV_ERR_EN
    logic         err;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, err
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, err
    );
`else
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done
    );
`endif

endinterface

// File: rtl/rsdiv_cp.sv
// Control FSM for the divider: IDLE -> LOAD -> (CHECK <-> SUB) -> DONE.
// Latency: done rises after edge 2q+2 counting the edge that samples start as 0.
// Backpressure: DONE holds while start stays high; start is ignored while busy.
// Ports: clk, rst (async, active-high), start, ge (rem>=div), dz (div==0);
// outputs ld, sub_en, busy, done (registered) and set_err.
module rsdiv_cp
    import rsdiv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ge,
    input  logic dz,
    output logic ld,
    output logic sub_en,
    output logic busy,
    output logic done,
    output logic set_err
);

    state_t state_q, state_d;
    logic   ld_q, ld_d;
    logic   sub_en_q, sub_en_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = CHECK;
            // A zero divisor must exit before any subtraction.
            CHECK:   state_d = (dz || !ge) ? DONE : SUB;
            SUB:     state_d = CHECK;
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered
        // yet line up with the state they describe.
        ld_d     = (state_d == LOAD);
        sub_en_d = (state_d == SUB);
        busy_d   = (state_d == LOAD) || (state_d == CHECK) || (state_d == SUB);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ld_q     <= 1'b0;
            sub_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_q     <= ld_d;
            sub_en_q <= sub_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ld     = ld_q;
    assign sub_en = sub_en_q;
    assign busy   = busy_q;
    assign done   = done_q;

    // Decoded from the current state so the error flag is written on the
    // very edge that takes CHECK to DONE, together with done.
    assign set_err = (state_q == CHECK) && dz;

endmodule

// File: rtl/rsdiv.sv
// Unsigned W-bit divider by repeated subtraction (datapath + rsdiv_cp FSM).
// Latency: 2q+2 edges from the edge sampling start to done; divide-by-zero is 2.
// Backpressure: requester holds start until done; results hold until next LOAD.
// Ports: clk, rst (async, active-high), bus (rsdiv_if.slave).
// Optional feature: define RSDIV_ERR_EN to add the err divide-by-zero flag.
module rsdiv
    import rsdiv_pkg::*;
#(
    parameter int W = W_DEF
)(
    input  logic    clk,
    input  logic    rst,
    rsdiv_if.slave  bus
);

    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] quo_q, quo_d;
    logic         ld, sub_en, ge, dz;
`ifdef RSDIV_ERR_EN
    logic         set_err;
    logic         err_q, err_d;
`else
    logic         set_err_unused;
`endif

    assign ge = (rem_q >= div_q);
    assign dz = (div_q == '0);

    rsdiv_cp u_cp (
        .clk     (clk),
        .rst     (rst),
        .start   (bus.start),
        .ge      (ge),
        .dz      (dz),
        .ld      (ld),
        .sub_en  (sub_en),
        .busy    (bus.busy),
        .done    (bus.done),
`ifdef RSDIV_ERR_EN
        .set_err (set_err)
`else
        .set_err (set_err_unused)
`endif
    );

    always_comb begin
        rem_d = rem_q;
        div_d = div_q;
        quo_d = quo_q;
        if (ld) begin
            rem_d = bus.dividend;
            div_d = bus.divisor;
            quo_d = '0;
        end else if (sub_en) begin
            // CHECK only enters SUB when rem >= div, so this cannot underflow.
            rem_d = rem_q - div_q;
            quo_d = quo_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            div_q <= '0;
            quo_q <= '0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
            quo_q <= quo_d;
        end
    end

`ifdef RSDIV_ERR_EN
    always_comb begin
        err_d = err_q;
        if (ld)           err_d = 1'b0;
        else if (set_err) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.err = err_q;
`endif

    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;

endmodule

// File: tb/tb_rsdiv.sv
// Directed self-checking bench for rsdiv (W=8).
// Latency: n/a.
// Backpressure: n/a.
module tb_rsdiv;
    import rsdiv_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    rsdiv_if #(.W(8)) bus ();

    rsdiv #(.W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and return the index of the edge after which done
    // is first seen (edge 0 samples start). start drops after edge drop_after.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input int drop_after, output int edge_n);
        int k;
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        k = -1;
        do begin
            @(negedge clk);
            k++;
            if (k == drop_after) bus.start = 1'b0;
        end while (!bus.done && k < 1000);
        edge_n = k;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.quotient !== 8'd0) begin
            errors++; $display("FAIL reset_quotient got=%0d exp=0", bus.quotient);
        end
        checks++;
        if (bus.remainder !== 8'd0) begin
            errors++; $display("FAIL reset_remainder got=%0d exp=0", bus.remainder);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", bus.busy, bus.done);
        end
`ifdef RSDIV_ERR_EN
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL reset_err got=%b exp=0", bus.err);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_divide();
        int va [6] = '{100, 5, 0, 255, 37, 7};
        int vb [6] = '{7,   9, 3, 1,   0,  7};
        int vq [6] = '{14,  0, 0, 255, 0,  1};
        int vr [6] = '{2,   5, 0, 0,   37, 0};
        int ve [6] = '{30,  2, 2, 512, 2,  4};
        int vz [6] = '{0,   0, 0, 0,   1,  0};
        int e;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i][7:0], vb[i][7:0], -1, e);
            checks++;
            if (e !== ve[i]) begin
                errors++; $display("FAIL div%0d_latency got=%0d exp=%0d", i, e, ve[i]);
            end
            checks++;
            if (bus.quotient !== vq[i][7:0]) begin
                errors++; $display("FAIL div%0d_quotient got=%0d exp=%0d", i, bus.quotient, vq[i]);
            end
            checks++;
            if (bus.remainder !== vr[i][7:0]) begin
                errors++; $display("FAIL div%0d_remainder got=%0d exp=%0d", i, bus.remainder, vr[i]);
            end
`ifdef RSDIV_ERR_EN
            checks++;
            if (bus.err !== vz[i][0]) begin
                errors++; $display("FAIL div%0d_err got=%b exp=%0d", i, bus.err, vz[i]);
            end
`else
            if (vz[i] > 1) $display("note: unexpected table value");
`endif
            bus.start = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL div%0d_idle done=%b busy=%b exp=0/0", i, bus.done, bus.busy);
            end
            checks++;
            if (bus.quotient !== vq[i][7:0] || bus.remainder !== vr[i][7:0]) begin
                errors++; $display("FAIL div%0d_hold q=%0d r=%0d exp=%0d/%0d",
                                   i, bus.quotient, bus.remainder, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int e;
        @(negedge clk);
        bus.dividend = 8'd200;
        bus.divisor  = 8'd3;
        bus.start    = 1'b1;
        // Negedges after edges 0..6: SUB at edges 3 and 5 done, now in SUB.
        repeat (7) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.quotient !== 8'd2) begin
            errors++; $display("FAIL midop_progress busy=%b q=%0d exp=1/2", bus.busy, bus.quotient);
        end
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.quotient !== 8'd0 || bus.remainder !== 8'd0) begin
            errors++; $display("FAIL midrst_data q=%0d r=%0d exp=0/0", bus.quotient, bus.remainder);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL midrst_flags busy=%b done=%b exp=0/0", bus.busy, bus.done);
        end
        checks++;
        if (dut.u_cp.state_q !== IDLE) begin
            errors++; $display("FAIL midrst_state got=%0d exp=%0d", dut.u_cp.state_q, IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(8'd9, 8'd4, -1, e);
        checks++;
        if (e !== 6 || bus.quotient !== 8'd2 || bus.remainder !== 8'd1) begin
            errors++; $display("FAIL after_rst_9div4 edge=%0d q=%0d r=%0d exp=6/2/1",
                               e, bus.quotient, bus.remainder);
        end
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold_start();
        int e;
        do_op(8'd9, 8'd4, -1, e);
        checks++;
        if (e !== 6) begin
            errors++; $display("FAIL hold_latency got=%0d exp=6", e);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 8'd2) begin
                errors++; $display("FAIL hold_cycle%0d done=%b busy=%b q=%0d exp=1/0/2",
                                   i, bus.done, bus.busy, bus.quotient);
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL hold_release done=%b exp=0", bus.done);
        end
    endtask

    task automatic test_drop_mid();
        int e;
        do_op(8'd100, 8'd7, 3, e);
        checks++;
        if (e !== 30 || bus.quotient !== 8'd14 || bus.remainder !== 8'd2) begin
            errors++; $display("FAIL drop_result edge=%0d q=%0d r=%0d exp=30/14/2",
                               e, bus.quotient, bus.remainder);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL drop_pulse done=%b busy=%b exp=0/0", bus.done, bus.busy);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_divide();
        test_reset_mid();
        test_hold_start();
        test_drop_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsdiv.md
RSDIV -- requirements
Module: rsdiv

Interface
REQ-001 Parameter W, default 8, sets the operand and result width in bits.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; level-held by the requester until done is seen.
REQ-005 dividend  input  W  unsigned dividend; stable while start is high.
REQ-006 divisor  input  W  unsigned divisor; stable while start is high.
REQ-007 quotient  output  W  registered quotient.
REQ-008 remainder  output  W  registered remainder.
REQ-009 busy  output  1  high in LOAD, CHECK and SUB.
REQ-010 done  output  1  high in DONE only.
REQ-011 err  output  1  divide-by-zero flag; present only when RSDIV_ERR_EN is defined.

Function
REQ-012 The block SHALL divide by repeated subtraction using an FSM with five states: IDLE, LOAD, CHECK, SUB and DONE.
REQ-013 In IDLE with start=1, the next state SHALL be LOAD; with start=0, the FSM SHALL stay in IDLE.
REQ-014 LOAD SHALL capture the operands: rem_r<=dividend, div_r<=divisor, quotient<=0, then next state CHECK.
REQ-015 CHECK SHALL go to DONE if div_r==0, else to SUB if rem_r>=div_r, else to DONE.
REQ-016 SUB SHALL perform rem_r<=rem_r-div_r and quotient<=quotient+1 in the same edge, then next state CHECK.
REQ-017 DONE SHALL assert done, stay while start=1, and go to IDLE when start=0.
REQ-018 remainder SHALL equal rem_r at all times.
REQ-019 All arithmetic SHALL be unsigned and W bits wide; the subtraction never underflows because of the CHECK guard.
REQ-020 Latency, counting the edge that samples start in IDLE as edge 0: done SHALL rise after edge 2q+2, where q is the final quotient.
REQ-021 Divide by zero SHALL terminate immediately with quotient=0 and remainder=dividend; no subtraction occurs.
REQ-022 quotient and remainder SHALL hold their values from DONE through IDLE until the next LOAD.
REQ-023 If start falls during LOAD, CHECK or SUB, the operation SHALL complete and done SHALL be high for exactly one cycle before IDLE.
REQ-024 start asserted while busy=1 SHALL have no effect beyond the current operation.
REQ-025 Back-to-back operations SHALL require start to be low for at least one cycle after done.

Reset
REQ-026 On rst: the FSM SHALL go to IDLE, and quotient, remainder, rem_r, div_r, done, busy and err SHALL all be 0.
REQ-027 rst asserted mid-operation SHALL abort the operation with no partial result retained.
REQ-028 The first operation after rst deassertion SHALL start from IDLE.

Configuration
REQ-029 Macro RSDIV_ERR_EN, when defined, SHALL add the err port and a flag register.
REQ-030 With RSDIV_ERR_EN, err SHALL be cleared in LOAD, set on the CHECK->DONE transition when div_r==0, and held until the next LOAD.
REQ-031 Without RSDIV_ERR_EN, there SHALL be no err port or flag register, and REQ-021 behaviour is unchanged.

Structure
REQ-032 Package rsdiv_pkg SHALL hold the state enum (IDLE, LOAD, CHECK, SUB, DONE; 3-bit encoding) and the default width constant.
REQ-033 The FSM SHALL be sub-module rsdiv_cp.
- rsdiv_cp inputs: clk, rst, start, ge (rem_r>=div_r), dz (div_r==0).
- rsdiv_cp outputs: ld, sub_en, busy, done, set_err.
REQ-034 The datapath registers, comparator and subtractor SHALL reside in rsdiv itself.

Verification
REQ-035 W=8, 100/7 -> quotient=14, remainder=2, done after edge 30, err=0.
REQ-036 5/9 -> quotient=0, remainder=5, done after edge 2; 0/3 -> quotient=0, remainder=0, done after edge 2.
REQ-037 255/1 -> quotient=255, remainder=0, done after edge 512, with no wrap.
REQ-038 37/0 -> quotient=0, remainder=37, done after edge 2, err=1 with the macro; no err port without it.
REQ-039 rst pulse during SUB of 200/3 -> all outputs 0 and IDLE; then 9/4 -> quotient=2, remainder=1.
REQ-040 Handshake checks:
- start held 10 cycles in DONE -> done stays high, no restart.
- start dropped mid-operation -> done is a single-cycle pulse.
